l15_int_decoder: RTL

//  Decodes L1.5 interrupt-return packets (returntype L15_INT_RET) arriving on the L15 return

---
 rtl/l15_int_decoder.sv | 70 +++++++
 1 files changed

// File: rtl/l15_int_decoder.sv
// l15_int_decoder: turns L1.5 interrupt-return packets into core wake-up, request enable,
// IPI level and debug-request pulses, with an optional sleep timeout wake-up.
module l15_int_decoder #(
   parameter int WakeTimeoutW = 16,
   parameter int UseTimeout = 0,
   parameter int IpiHoldCycles = 4,
   parameter int DbgPulseCycles = 2,
   parameter logic [3:0] IntRetType = 4'b0111
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rtrn_val_i,
   input  logic [3:0]  rtrn_type_i,
   input  logic [63:0] rtrn_data0_i,
   output logic        wake_up_o,
   output logic        req_en_o,
   output logic        ipi_o,
   output logic        debug_req_o,
   output logic        idle_o
);
   localparam int IW = $clog2(IpiHoldCycles + 1);
   localparam int DW = $clog2(DbgPulseCycles + 1);
   typedef enum logic [1:0] {SLEEP, AWAKE, PARKED} state_t;
   state_t state;
   logic [WakeTimeoutW-1:0] tmo_cnt;
   logic [IW-1:0] ipi_cnt;
   logic [DW-1:0] dbg_cnt;
   logic [1:0] cls;
   logic [5:0] vec;
   logic q, pwr_on, dbg, ipi, idle, resume, timeout, unused_bits;
   assign cls = rtrn_data0_i[17:16];
   assign vec = rtrn_data0_i[5:0];
   assign unused_bits = ^{rtrn_data0_i[63:18], rtrn_data0_i[15:6]};
   assign q = rtrn_val_i && rtrn_type_i == IntRetType;
   assign pwr_on = q && cls == 2'b01 && vec == 6'd1;
   assign dbg = q && cls == 2'b01 && vec == 6'd2;
   assign ipi = q && cls == 2'b00;
   assign idle = q && cls == 2'b10;
   assign resume = q && cls == 2'b11;
   assign timeout = tmo_cnt[WakeTimeoutW-1];
   assign req_en_o = state == AWAKE;
   assign idle_o = state == PARKED;
   assign ipi_o = ipi_cnt != '0;
   assign debug_req_o = dbg_cnt != '0;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= SLEEP;
         wake_up_o <= 1'b0;
         tmo_cnt <= '0;
         ipi_cnt <= '0;
         dbg_cnt <= '0;
      end else begin
         // counter saturates at its MSB so the timeout stays asserted
         if (state == SLEEP && !timeout) tmo_cnt <= tmo_cnt + WakeTimeoutW'(1);
         case (state)
            SLEEP: if (pwr_on || (UseTimeout != 0 && timeout)) begin
               state <= AWAKE;
               wake_up_o <= 1'b1;
            end
            AWAKE: if (idle) state <= PARKED;
            PARKED: if (resume || pwr_on || ipi) state <= AWAKE;
            default: state <= SLEEP;
         endcase
         if (ipi && state != SLEEP) ipi_cnt <= IW'(IpiHoldCycles);
         else if (ipi_cnt != '0) ipi_cnt <= ipi_cnt - IW'(1);
         if (dbg) dbg_cnt <= DW'(DbgPulseCycles);
         else if (dbg_cnt != '0) dbg_cnt <= dbg_cnt - DW'(1);
      end
   end
endmodule
